// File: rtl/sort_run_ctrl_if.sv
// Element-load stream, shared data-memory port and result-dump stream of sort_run_ctrl.
// master = controller side, slave = source/memory/sink side.
interface sort_run_ctrl_if;
    logic        src_valid;
    logic [63:0] src_data;
    logic        src_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        dump_valid;
    logic [63:0] dump_data;
    logic        dump_ready;

    modport master (
        input  src_valid, src_data, mem_rdata, dump_ready,
        output src_ready, mem_we, mem_addr, mem_wdata, dump_valid, dump_data
    );

    modport slave (
        output src_valid, src_data, mem_rdata, dump_ready,
        input  src_ready, mem_we, mem_addr, mem_wdata, dump_valid, dump_data
    );
endinterface

// File: rtl/sort_run_ctrl.sv
// Load/run/dump sequencer for a sort program running on a processor that shares one data memory.
// Optional macro SORT_CHECK_EN adds a signed ascending-order checker on the dumped beats.
module sort_run_ctrl #(
    parameter int unsigned N_ELEM     = 8,
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter logic [63:0] END_PC     = 64'h0000_0000_0000_0080,
    parameter int unsigned MAX_CYCLES = 20000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    sort_run_ctrl_if.master bus,
    output logic            core_reset,
    output logic            mem_owner,
    input  logic [63:0]     pc,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [31:0]     cycles,
    output logic            sorted_err
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, DONE, TIMEOUT} state_t;

    localparam logic [7:0]  LAST_IDX  = 8'(N_ELEM - 1);
    localparam logic [31:0] CYCLE_LIM = 32'(MAX_CYCLES);

    state_t      state;
    logic [7:0]  idx;
    logic        pc_hit_prev;
    logic        pc_hit;
    logic        run_end;
    logic        src_xfer;
    logic        dump_accept;
    logic        restart;
    logic [31:0] cycles_inc;

    assign pc_hit      = (pc == END_PC);
    assign run_end     = pc_hit && pc_hit_prev;
    assign cycles_inc  = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
    assign src_xfer    = bus.src_valid && bus.src_ready;
    assign dump_accept = bus.dump_valid && bus.dump_ready;
    assign restart     = start && (state == IDLE || state == DONE || state == TIMEOUT);

    // Writes happen in the transfer cycle itself; src_ready is only high in LOAD.
    assign bus.mem_we    = src_xfer;
    assign bus.mem_addr  = BASE_ADDR + {53'd0, idx, 3'd0};
    assign bus.mem_wdata = bus.src_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            idx            <= '0;
            pc_hit_prev    <= 1'b0;
            cycles         <= '0;
            core_reset     <= 1'b1;
            mem_owner      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            bus.src_ready  <= 1'b0;
            bus.dump_valid <= 1'b0;
            bus.dump_data  <= '0;
        end else begin
            case (state)
                IDLE, DONE, TIMEOUT: begin
                    if (restart) begin
                        state         <= LOAD;
                        idx           <= '0;
                        cycles        <= '0;
                        done          <= 1'b0;
                        timeout       <= 1'b0;
                        busy          <= 1'b1;
                        bus.src_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (src_xfer) begin
                        if (idx == LAST_IDX) begin
                            state         <= RUN;
                            idx           <= '0;
                            bus.src_ready <= 1'b0;
                            core_reset    <= 1'b0;
                            mem_owner     <= 1'b0;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end
                // The cycle that confirms the end is not counted; an end on the limit cycle beats the timeout.
                RUN: begin
                    pc_hit_prev <= pc_hit;
                    if (run_end) begin
                        state       <= DUMP;
                        core_reset  <= 1'b1;
                        mem_owner   <= 1'b1;
                        pc_hit_prev <= 1'b0;
                    end else begin
                        cycles <= cycles_inc;
                        if (cycles_inc >= CYCLE_LIM) begin
                            state       <= TIMEOUT;
                            timeout     <= 1'b1;
                            busy        <= 1'b0;
                            core_reset  <= 1'b1;
                            mem_owner   <= 1'b1;
                            pc_hit_prev <= 1'b0;
                        end
                    end
                end
                // Each beat: fetch at idx, present it, then hold until the sink accepts.
                DUMP: begin
                    if (!bus.dump_valid) begin
                        bus.dump_data  <= bus.mem_rdata;
                        bus.dump_valid <= 1'b1;
                    end else if (dump_accept) begin
                        bus.dump_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SORT_CHECK_EN
    logic signed [63:0] prev_beat;

    // Sticky flag: any accepted beat smaller (signed) than the one before it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sorted_err <= 1'b0;
            prev_beat  <= '0;
        end else if (restart) begin
            sorted_err <= 1'b0;
        end else if (dump_accept) begin
            prev_beat <= $signed(bus.dump_data);
            if (idx != 8'd0 && $signed(bus.dump_data) < prev_beat) begin
                sorted_err <= 1'b1;
            end
        end
    end
`else
    assign sorted_err = 1'b0;
`endif

endmodule
